// File: rtl/pet_io_pkg.sv
// Shared types and constants for the PET I/O region controller.
package pet_io_pkg;

    localparam int MAX_DEV = 8;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT,
        CAPTURE
    } state_t;

    localparam logic [1:0] REG_IRQ_PEND = 2'd0;
    localparam logic [1:0] REG_IRQ_MASK = 2'd1;
    localparam logic [1:0] REG_IRQ_EDGE = 2'd2;
    localparam logic [1:0] REG_BUS_STAT = 2'd3;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [2:0] lowest_set(input logic [MAX_DEV-1:0] v);
        logic       found;
        logic [2:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < MAX_DEV; i++) begin
            if (v[i] && !found) begin
                idx   = 3'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/pet_io_bus_if.sv
// CPU-side bus of the PET I/O region: access request, ready, read data and interrupt.
interface pet_io_bus_if #(
    parameter int ADDR_W = 8
);
    logic              ce;
    logic              cs;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data_in;
    logic [7:0]        data_out;
    logic              rdy;
    logic              irq;

    modport master (output ce, cs, we, addr, data_in, input data_out, rdy, irq);
    modport slave  (input ce, cs, we, addr, data_in, output data_out, rdy, irq);
endinterface

// File: rtl/pet_io_irqctl.sv
// Interrupt controller: per-device mask, edge/level mode, latched edge pending and registered irq.
module pet_io_irqctl
    import pet_io_pkg::*;
#(
    parameter int NUM_DEV = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DEV-1:0] dev_irq,
    input  logic               wr_en,
    input  logic [1:0]         wr_addr,
    input  logic [NUM_DEV-1:0] wr_data,
    output logic [NUM_DEV-1:0] mask,
    output logic [NUM_DEV-1:0] edge_mode,
    output logic [NUM_DEV-1:0] pending,
    output logic               irq
);

    logic [NUM_DEV-1:0] mask_q, edge_q, latch_q, prev_q, rise;
    logic               irq_q;

    always_comb begin
        rise    = dev_irq & ~prev_q & edge_q;
        pending = (edge_q & latch_q) | (~edge_q & dev_irq);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q  <= '1;
            edge_q  <= '0;
            latch_q <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            prev_q <= dev_irq;
            irq_q  <= |(pending & mask_q);
            if (wr_en && wr_addr == REG_IRQ_MASK)
                mask_q <= wr_data;
            // A new edge beats a simultaneous W1C; leaving edge mode drops the latched state.
            if (wr_en && wr_addr == REG_IRQ_EDGE) begin
                edge_q  <= wr_data;
                latch_q <= (latch_q | rise) & wr_data;
            end else if (wr_en && wr_addr == REG_IRQ_PEND) begin
                latch_q <= (latch_q & ~wr_data) | rise;
            end else begin
                latch_q <= latch_q | rise;
            end
        end
    end

    assign mask      = mask_q;
    assign edge_mode = edge_q;
    assign irq       = irq_q;

endmodule

// File: rtl/pet_io_bus.sv
// PET I/O region controller: one-hot device decode, strobes, ack wait states with timeout,
// wired-AND read mux, CPU RDY, IRQ controller and bus-status register.
module pet_io_bus
    import pet_io_pkg::*;
#(
    parameter int                 NUM_DEV  = 3,
    parameter int                 SEL_LSB  = 4,
    parameter int                 ADDR_W   = 8,
    parameter logic [NUM_DEV-1:0] ACK_MASK = '0,
    parameter int                 TIMEOUT  = 15,
    parameter bit                 CTRL_EN  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    pet_io_bus_if.slave            bus,
    output logic [NUM_DEV-1:0]     dev_sel,
    output logic [NUM_DEV-1:0]     dev_strobe,
    input  logic [8*NUM_DEV-1:0]   dev_data,
    input  logic [NUM_DEV-1:0]     dev_ack,
    input  logic [NUM_DEV-1:0]     dev_irq
);

    if (NUM_DEV < 1 || NUM_DEV > MAX_DEV) begin : g_bad_num_dev
        $error("pet_io_bus: NUM_DEV out of range");
    end
    if (SEL_LSB + NUM_DEV > ADDR_W) begin : g_bad_sel
        $error("pet_io_bus: select bits exceed ADDR_W");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("pet_io_bus: TIMEOUT out of range");
    end

    // Counter value during the last permitted WAIT cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [NUM_DEV-1:0] sel_q, ack_q, wdata_q, need, ack_all;
    logic [NUM_DEV-1:0] mask, edge_mode, pending;
    logic               ctrl_q, we_q, to_q, to_flag_q, rdy_q;
    logic               ack_done, cnt_hit, wr_ctrl, irq_w;
    logic [1:0]         reg_q;
    logic [7:0]         cnt_q, data_out_q, dev_rd, rd_ctrl, rd_val;
    logic [2:0]         last_dev_q;
    logic [MAX_DEV-1:0] unacked;

    always_comb begin
        need     = sel_q & ACK_MASK;
        ack_all  = ack_q | dev_ack;
        ack_done = ((ack_all & need) == need);
        cnt_hit  = (cnt_q == TO_LAST);
        wr_ctrl  = (state_q == CAPTURE) && we_q && ctrl_q;
        unacked  = '0;
        unacked[NUM_DEV-1:0] = need & ~ack_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ce && bus.cs) state_d = STROBE;
            STROBE:  state_d = (need != '0) ? WAIT : CAPTURE;
            WAIT:    if (ack_done || cnt_hit) state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dev_strobe = '0;
        dev_sel    = '0;
        if (state_q == STROBE) dev_strobe = sel_q;
        if (state_q != IDLE)   dev_sel    = sel_q;
    end

    always_comb begin
        dev_rd = 8'hFF;
        for (int unsigned i = 0; i < NUM_DEV; i++) begin
            if (sel_q[i]) dev_rd &= dev_data[8*i +: 8];
        end
        rd_ctrl = '0;
        case (reg_q)
            REG_IRQ_PEND: rd_ctrl[NUM_DEV-1:0] = pending;
            REG_IRQ_MASK: rd_ctrl[NUM_DEV-1:0] = mask;
            REG_IRQ_EDGE: rd_ctrl[NUM_DEV-1:0] = edge_mode;
            default:      rd_ctrl = {1'b0, last_dev_q, 3'b000, to_flag_q};
        endcase
        // With no select bits and no control decode, dev_rd is already all ones.
        rd_val = to_q ? 8'hFF : (ctrl_q ? rd_ctrl : dev_rd);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            ack_q      <= '0;
            wdata_q    <= '0;
            ctrl_q     <= 1'b0;
            we_q       <= 1'b0;
            reg_q      <= '0;
            cnt_q      <= '0;
            to_q       <= 1'b0;
            to_flag_q  <= 1'b0;
            last_dev_q <= '0;
            rdy_q      <= 1'b1;
            data_out_q <= 8'hFF;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.ce && bus.cs) begin
                        sel_q   <= bus.addr[SEL_LSB +: NUM_DEV];
                        ctrl_q  <= CTRL_EN && (bus.addr[SEL_LSB +: NUM_DEV] == '0);
                        we_q    <= bus.we;
                        reg_q   <= bus.addr[1:0];
                        wdata_q <= bus.data_in[NUM_DEV-1:0];
                        ack_q   <= '0;
                        to_q    <= 1'b0;
                        rdy_q   <= 1'b0;
                    end
                end
                STROBE: begin
                    ack_q <= ack_q | dev_ack;
                    cnt_q <= '0;
                end
                WAIT: begin
                    ack_q <= ack_all;
                    cnt_q <= cnt_q + 8'd1;
                    if (cnt_hit && !ack_done) to_q <= 1'b1;
                end
                CAPTURE: begin
                    if (!we_q) data_out_q <= rd_val;
                    if (to_q) begin
                        to_flag_q  <= 1'b1;
                        last_dev_q <= lowest_set(unacked);
                    end else if (wr_ctrl && reg_q == REG_BUS_STAT) begin
                        to_flag_q  <= 1'b0;
                        last_dev_q <= '0;
                    end
                    rdy_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    pet_io_irqctl #(
        .NUM_DEV(NUM_DEV)
    ) u_irqctl (
        .clk      (clk),
        .reset    (reset),
        .dev_irq  (dev_irq),
        .wr_en    (wr_ctrl),
        .wr_addr  (reg_q),
        .wr_data  (wdata_q),
        .mask     (mask),
        .edge_mode(edge_mode),
        .pending  (pending),
        .irq      (irq_w)
    );

    assign bus.data_out = data_out_q;
    assign bus.rdy      = rdy_q;
    assign bus.irq      = irq_w;

endmodule
